call_ret_stack_unit: RTL and testbench

//  Responder side of the EX-stage call/return interface. Consumes call/ret

---
 rtl/call_ret_stack_unit_pkg.sv | 21 ++
 rtl/call_ret_stack_unit_if.sv | 31 +++
 rtl/call_ret_stack_unit_stack_ptr_reg.sv | 32 +++
 rtl/call_ret_stack_unit.sv | 119 +++++++++++
 tb/tb_call_ret_stack_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/call_ret_stack_unit_pkg.sv
// Shared types and constants for the call/return stack unit.
// The SP register index tells the writeback path which architectural register the sp_we pulse updates.
package call_ret_stack_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUSH  = 2'd1,
        POP   = 2'd2,
        RDONE = 2'd3
    } stack_state_t;

    localparam logic [3:0]  SP_REG_IDX   = 4'b1111;
    localparam logic [15:0] SP_RESET_DEF = 16'hFFFF;
    localparam logic [15:0] SP_LIMIT_DEF = 16'hFF00;

    // SP always names the next free slot, so the top of stack sits one above it
    function automatic logic [15:0] pop_addr(input logic [15:0] sp);
        return sp + 16'd1;
    endfunction

endpackage

// File: rtl/call_ret_stack_unit_if.sv
// EX call/ret request, stack memory port and SP/return-PC writeback, bundled.
// The slave modport is the stack unit; the master modport is its environment.
interface call_ret_stack_unit_if;
    logic        call_in;
    logic        ret_in;
    logic [15:0] push_pc;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ret_wb;
    logic [15:0] PC_stack_pointer;
    logic        sp_we;
    logic [15:0] sp_out;
    logic        stall_out;
    logic        stack_err;

    modport slave (
        input  call_in, ret_in, push_pc, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, ret_wb,
               PC_stack_pointer, sp_we, sp_out, stall_out, stack_err
    );

    modport master (
        output call_in, ret_in, push_pc, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, ret_wb,
               PC_stack_pointer, sp_we, sp_out, stall_out, stack_err
    );
endinterface

// File: rtl/call_ret_stack_unit_stack_ptr_reg.sv
// Stack pointer register with increment/decrement and empty/limit compares.
// Single-cycle update; inc takes priority if both enables are ever raised.
module call_ret_stack_unit_stack_ptr_reg
    import call_ret_stack_unit_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEF,
    parameter logic [15:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] sp,
    output logic        at_empty,
    output logic        at_limit
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= SP_RESET;
        end else if (inc) begin
            sp <= sp + 16'd1;
        end else if (dec) begin
            sp <= sp - 16'd1;
        end
    end

    assign at_empty = (sp == SP_RESET);
    // at_limit means the next push would land below the lowest legal address
    assign at_limit = (sp < SP_LIMIT);

endmodule

// File: rtl/call_ret_stack_unit.sv
// Call/return responder: pushes return PCs to, and pops them from, the memory stack; owns the SP shadow.
// Call completes 1 cycle after ack, ret_wb 1 cycle after ack; stall_out high whenever the FSM is busy.
module call_ret_stack_unit
    import call_ret_stack_unit_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEF,
    parameter logic [15:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    call_ret_stack_unit_if.slave  bus
);

    stack_state_t state, state_nxt;
    logic [15:0]  pc_lat;
    logic [15:0]  pc_ret;
    logic         err;
    logic         sp_we_q;

    logic         sp_inc, sp_dec;
    logic         latch_pc, cap_rd, clr_ret, set_err, push_done;
    logic [15:0]  sp;
    logic         at_empty, at_limit;

    call_ret_stack_unit_stack_ptr_reg #(
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp (
        .clk      (clk),
        .rst      (rst),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp),
        .at_empty (at_empty),
        .at_limit (at_limit)
    );

    always_comb begin
        state_nxt = state;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        latch_pc  = 1'b0;
        cap_rd    = 1'b0;
        clr_ret   = 1'b0;
        set_err   = 1'b0;
        push_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.call_in) begin
                    // a simultaneous ret is dropped and flagged; the call still proceeds
                    if (bus.ret_in) set_err = 1'b1;
                    if (at_limit) begin
                        set_err = 1'b1;
                    end else begin
                        latch_pc  = 1'b1;
                        state_nxt = PUSH;
                    end
                end else if (bus.ret_in) begin
                    if (at_empty) begin
                        // empty stack: still answer with PC 0 so EX does not hang
                        set_err   = 1'b1;
                        clr_ret   = 1'b1;
                        state_nxt = RDONE;
                    end else begin
                        state_nxt = POP;
                    end
                end
            end
            PUSH: begin
                if (bus.mem_ack) begin
                    sp_dec    = 1'b1;
                    push_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            POP: begin
                if (bus.mem_ack) begin
                    sp_inc    = 1'b1;
                    cap_rd    = 1'b1;
                    state_nxt = RDONE;
                end
            end
            RDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc_lat  <= 16'h0000;
            pc_ret  <= 16'h0000;
            err     <= 1'b0;
            sp_we_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            sp_we_q <= push_done;
            if (latch_pc) pc_lat <= bus.push_pc;
            if (cap_rd) begin
                pc_ret <= bus.mem_rdata;
            end else if (clr_ret) begin
                pc_ret <= 16'h0000;
            end
            if (set_err) err <= 1'b1;
        end
    end

    assign bus.mem_req          = (state == PUSH) || (state == POP);
    assign bus.mem_we           = (state == PUSH);
    assign bus.mem_addr         = (state == POP) ? pop_addr(sp) : sp;
    assign bus.mem_wdata        = pc_lat;
    assign bus.ret_wb           = (state == RDONE);
    assign bus.PC_stack_pointer = pc_ret;
    assign bus.sp_we            = sp_we_q || (state == RDONE);
    assign bus.sp_out           = sp;
    assign bus.stall_out        = (state != IDLE);
    assign bus.stack_err        = err;

endmodule

// File: tb/tb_call_ret_stack_unit.sv
// Directed bench for call_ret_stack_unit: push/pop, nesting, under/overflow, conflict, reset mid-pop.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_call_ret_stack_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    logic [15:0] smem [0:255];

    call_ret_stack_unit_if bus ();
    call_ret_stack_unit_if bus2 ();

    call_ret_stack_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    call_ret_stack_unit #(
        .SP_RESET (16'hFFFF),
        .SP_LIMIT (16'hFFFE)
    ) dut_lim (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [15:0] pc, input int waits, input logic [15:0] exp_sp);
        logic [15:0] sp_after;
        sp_after = exp_sp - 16'd1;
        bus.call_in = 1'b1;
        bus.push_pc = pc;
        tick();
        bus.call_in = 1'b0;
        check("push_req",   {31'd0, bus.mem_req}, 1);
        check("push_we",    {31'd0, bus.mem_we}, 1);
        check("push_addr",  {16'd0, bus.mem_addr}, {16'd0, exp_sp});
        check("push_wdata", {16'd0, bus.mem_wdata}, {16'd0, pc});
        check("push_stall", {31'd0, bus.stall_out}, 1);
        for (int i = 0; i < waits; i++) begin
            tick();
            check("push_hold_req",  {31'd0, bus.mem_req}, 1);
            check("push_hold_addr", {16'd0, bus.mem_addr}, {16'd0, exp_sp});
        end
        bus.mem_ack = 1'b1;
        smem[bus.mem_addr[7:0]] = bus.mem_wdata;
        tick();
        bus.mem_ack = 1'b0;
        check("push_sp_we",  {31'd0, bus.sp_we}, 1);
        check("push_sp_out", {16'd0, bus.sp_out}, {16'd0, sp_after});
        check("push_done_stall", {31'd0, bus.stall_out}, 0);
        check("push_done_req",   {31'd0, bus.mem_req}, 0);
        tick();
        check("push_sp_we_off", {31'd0, bus.sp_we}, 0);
    endtask

    task automatic do_ret(input int waits, input logic [15:0] exp_addr, input logic [15:0] exp_pc);
        bus.ret_in = 1'b1;
        tick();
        bus.ret_in = 1'b0;
        check("pop_req",  {31'd0, bus.mem_req}, 1);
        check("pop_we",   {31'd0, bus.mem_we}, 0);
        check("pop_addr", {16'd0, bus.mem_addr}, {16'd0, exp_addr});
        for (int i = 0; i < waits; i++) begin
            tick();
            check("pop_hold_req", {31'd0, bus.mem_req}, 1);
            check("pop_hold_wb",  {31'd0, bus.ret_wb}, 0);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = smem[bus.mem_addr[7:0]];
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        check("pop_ret_wb", {31'd0, bus.ret_wb}, 1);
        check("pop_pc",     {16'd0, bus.PC_stack_pointer}, {16'd0, exp_pc});
        check("pop_sp_we",  {31'd0, bus.sp_we}, 1);
        check("pop_sp_out", {16'd0, bus.sp_out}, {16'd0, exp_addr});
        check("pop_rdone_req", {31'd0, bus.mem_req}, 0);
        tick();
        check("pop_ret_wb_off", {31'd0, bus.ret_wb}, 0);
        check("pop_stall_off",  {31'd0, bus.stall_out}, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 256; i++) smem[i] = 16'h0000;
        bus.call_in    = 1'b0;
        bus.ret_in     = 1'b0;
        bus.push_pc    = 16'h0000;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 16'h0000;
        bus2.call_in   = 1'b0;
        bus2.ret_in    = 1'b0;
        bus2.push_pc   = 16'h0000;
        bus2.mem_ack   = 1'b1;
        bus2.mem_rdata = 16'h0000;
        rst = 1'b1;
        tick();
        tick();

        check("rst_sp",    {16'd0, bus.sp_out}, 32'h0000FFFF);
        check("rst_pc",    {16'd0, bus.PC_stack_pointer}, 0);
        check("rst_req",   {31'd0, bus.mem_req}, 0);
        check("rst_ret_wb",{31'd0, bus.ret_wb}, 0);
        check("rst_sp_we", {31'd0, bus.sp_we}, 0);
        check("rst_stall", {31'd0, bus.stall_out}, 0);
        check("rst_err",   {31'd0, bus.stack_err}, 0);
        rst = 1'b0;

        // single call then ret with three wait cycles
        do_call(16'h0123, 0, 16'hFFFF);
        check("mem_0123", {16'd0, smem[8'hFF]}, 32'h00000123);
        do_ret(3, 16'hFFFF, 16'h0123);

        // nested calls unwind in reverse order
        do_call(16'hA00A, 0, 16'hFFFF);
        do_call(16'hB00B, 1, 16'hFFFE);
        do_call(16'hC00C, 2, 16'hFFFD);
        check("nest_sp", {16'd0, bus.sp_out}, 32'h0000FFFC);
        do_ret(0, 16'hFFFD, 16'hC00C);
        do_ret(1, 16'hFFFE, 16'hB00B);
        do_ret(0, 16'hFFFF, 16'hA00A);
        check("nest_sp_back", {16'd0, bus.sp_out}, 32'h0000FFFF);
        check("nest_no_err",  {31'd0, bus.stack_err}, 0);

        // underflow
        bus.ret_in = 1'b1;
        tick();
        bus.ret_in = 1'b0;
        check("uf_req",    {31'd0, bus.mem_req}, 0);
        check("uf_err",    {31'd0, bus.stack_err}, 1);
        check("uf_ret_wb", {31'd0, bus.ret_wb}, 1);
        check("uf_pc",     {16'd0, bus.PC_stack_pointer}, 0);
        tick();
        check("uf_ret_wb_off", {31'd0, bus.ret_wb}, 0);
        check("uf_sp",         {16'd0, bus.sp_out}, 32'h0000FFFF);
        check("uf_err_sticky", {31'd0, bus.stack_err}, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_err", {31'd0, bus.stack_err}, 0);

        // call and ret together: push only, error flagged
        bus.call_in = 1'b1;
        bus.ret_in  = 1'b1;
        bus.push_pc = 16'h0BEE;
        tick();
        bus.call_in = 1'b0;
        bus.ret_in  = 1'b0;
        check("both_req",  {31'd0, bus.mem_req}, 1);
        check("both_we",   {31'd0, bus.mem_we}, 1);
        check("both_addr", {16'd0, bus.mem_addr}, 32'h0000FFFF);
        check("both_err",  {31'd0, bus.stack_err}, 1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("both_sp",     {16'd0, bus.sp_out}, 32'h0000FFFE);
        check("both_ret_wb", {31'd0, bus.ret_wb}, 0);
        tick();
        check("both_idle_req", {31'd0, bus.mem_req}, 0);
        check("both_idle_wb",  {31'd0, bus.ret_wb}, 0);

        // reset in the middle of a pop
        bus.ret_in = 1'b1;
        tick();
        bus.ret_in = 1'b0;
        check("mid_pop_req",  {31'd0, bus.mem_req}, 1);
        check("mid_pop_addr", {16'd0, bus.mem_addr}, 32'h0000FFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pop_req", {31'd0, bus.mem_req}, 0);
        check("rst_pop_sp",  {16'd0, bus.sp_out}, 32'h0000FFFF);
        check("rst_pop_wb",  {31'd0, bus.ret_wb}, 0);
        check("rst_pop_err", {31'd0, bus.stack_err}, 0);
        tick();
        check("rst_pop_wb2",  {31'd0, bus.ret_wb}, 0);
        check("rst_pop_req2", {31'd0, bus.mem_req}, 0);

        // overflow on the instance with SP_LIMIT=FFFE, memory acks immediately
        bus2.call_in = 1'b1;
        bus2.push_pc = 16'h1111;
        tick();
        bus2.call_in = 1'b0;
        check("ov_push1_addr", {16'd0, bus2.mem_addr}, 32'h0000FFFF);
        tick();
        bus2.call_in = 1'b1;
        bus2.push_pc = 16'h2222;
        tick();
        bus2.call_in = 1'b0;
        check("ov_push2_addr", {16'd0, bus2.mem_addr}, 32'h0000FFFE);
        tick();
        check("ov_sp_at_lim", {16'd0, bus2.sp_out}, 32'h0000FFFD);
        check("ov_no_err",    {31'd0, bus2.stack_err}, 0);
        bus2.call_in = 1'b1;
        bus2.push_pc = 16'h3333;
        tick();
        bus2.call_in = 1'b0;
        check("ov_req",   {31'd0, bus2.mem_req}, 0);
        check("ov_stall", {31'd0, bus2.stall_out}, 0);
        check("ov_err",   {31'd0, bus2.stack_err}, 1);
        check("ov_sp",    {16'd0, bus2.sp_out}, 32'h0000FFFD);
        tick();
        check("ov_req2",   {31'd0, bus2.mem_req}, 0);
        check("ov_ret_wb", {31'd0, bus2.ret_wb}, 0);
        check("ov_sp2",    {16'd0, bus2.sp_out}, 32'h0000FFFD);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
